exe_mem_pipe_stage: RTL

Parametrised successor to the fixed EXE/MEM pipeline register: carries the write-back/memory control bits, ALU result, store value and destination register from execute to memory stage. Adds a valid/ready handshake with a one-entry skid buffer so stalls never combinationally cross the stage, a synchronous flush for branch squash, forwarding taps for the hazard unit and a saturating back-pressure counter. Sits between the execute stage output and the data-memory stage input.

---
 rtl/exe_mem_pipe_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/exe_mem_pipe_stage.sv
// rtl/exe_mem_pipe_stage.sv - EXE/MEM pipeline register with skid buffer, flush, forwarding taps and stall counter
//
// Purpose: carries write-back/memory control bits, ALU result, store value and
// destination register from execute to memory stage behind a valid/ready
// handshake. A one-entry skid buffer keeps in_ready purely register-derived.
//
// Ports:
//   clk, rst (async active-low)          clock and reset
//   flush                                synchronous squash of held beats
//   in_valid / in_ready + *_in fields    upstream beat
//   out_valid / out_ready + outputs      downstream beat (control gated by out_valid)
//   fwd_valid / fwd_dest / fwd_data      hazard-unit forwarding taps
//   stall_cnt / stall_clr                saturating back-pressure cycle counter
module exe_mem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_result_in,
    input  logic [DATA_W-1:0] ST_val_in,
    input  logic [DEST_W-1:0] Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] ST_val,
    output logic [DEST_W-1:0] Dest,
    output logic              fwd_valid,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // Beat layout: {WB_en, MEM_R_EN, MEM_W_EN, Dest, ST_val, ALU_result}
    localparam int BEAT_W = 3 + DEST_W + 2 * DATA_W;
    localparam int ST_LO  = DATA_W;
    localparam int DST_LO = 2 * DATA_W;
    localparam int MW_B   = DST_LO + DEST_W;
    localparam int MR_B   = MW_B + 1;
    localparam int WB_B   = MW_B + 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   main_q, main_d;
    logic [BEAT_W-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic [BEAT_W-1:0]   in_beat;
    logic                main_valid;
    logic                skid_valid;
    logic                accept;
    logic                drain;

    assign in_beat    = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, Dest_in, ST_val_in, ALU_result_in};
    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == FULL);

    // Only the skid valid bit gates acceptance, so a downstream stall never
    // reaches upstream combinationally.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_beat;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = in_beat;
                end else if (accept) begin
                    skid_d  = in_beat;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Squash drops held beats and anything accepted this cycle; data
        // registers may keep stale contents since valid bits are cleared.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (stall_clr) begin
            stall_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    // Control bits become a bubble when no beat is present.
    assign WB_en      = out_valid & main_q[WB_B];
    assign MEM_R_EN   = out_valid & main_q[MR_B];
    assign MEM_W_EN   = out_valid & main_q[MW_B];
    assign ALU_result = main_q[DATA_W-1:0];
    assign ST_val     = main_q[ST_LO +: DATA_W];
    assign Dest       = main_q[DST_LO +: DEST_W];

    assign fwd_valid  = WB_en;
    assign fwd_dest   = Dest;
    assign fwd_data   = ALU_result;

    assign stall_cnt  = stall_q;

endmodule
